// File: rtl/axil_ram_responder.sv
// AXI4-lite slave terminating writes and reads into a byte-enabled on-chip RAM.
// Write: 1 cycle to awready/wready/bvalid, B holds until bready. Read: 1 cycle (+1 with PIPELINE_OUTPUT), R holds until rready.
module axil_ram_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] ram_rd_dat;

  logic                  aw_rdy_q, aw_rdy_d;
  logic                  b_vld_q, b_vld_d;
  logic                  ar_rdy_q, ar_rdy_d;
  logic                  r_vld_q, r_vld_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  st_vld_q, st_vld_d;
  logic [DATA_WIDTH-1:0] st_dat_q, st_dat_d;

  logic w_accept;
  logic r_accept;
  logic out_load;

  // Protection bits and the byte offset carry no meaning for this RAM.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  assign aw_idx     = s_axil_awaddr[ADDR_WIDTH-1:OFF_W];
  assign ar_idx     = s_axil_araddr[ADDR_WIDTH-1:OFF_W];
  assign ram_rd_dat = mem[ar_idx];

  always_comb begin
    w_accept = s_axil_awvalid && s_axil_wvalid && !aw_rdy_q && (!b_vld_q || s_axil_bready);
    aw_rdy_d = w_accept;
    b_vld_d  = b_vld_q && !s_axil_bready;
    if (w_accept) begin
      b_vld_d = 1'b1;
    end
  end

  always_comb begin
    out_load = !r_vld_q || s_axil_rready;
    r_accept = 1'b0;
    r_vld_d  = r_vld_q;
    rdata_d  = rdata_q;
    st_vld_d = st_vld_q;
    st_dat_d = st_dat_q;
    if (PIPELINE_OUTPUT != 0) begin
      // Intermediate stage may accept when empty or when it drains into the output this cycle.
      r_accept = s_axil_arvalid && !ar_rdy_q && (!st_vld_q || out_load);
      if (out_load) begin
        r_vld_d  = st_vld_q;
        st_vld_d = 1'b0;
        if (st_vld_q) begin
          rdata_d = st_dat_q;
        end
      end
      if (r_accept) begin
        st_vld_d = 1'b1;
        st_dat_d = ram_rd_dat;
      end
    end else begin
      r_accept = s_axil_arvalid && !ar_rdy_q && out_load;
      if (out_load) begin
        r_vld_d = 1'b0;
      end
      if (r_accept) begin
        r_vld_d = 1'b1;
        rdata_d = ram_rd_dat;
      end
    end
    ar_rdy_d = r_accept;
  end

  // No reset on the array; the read above sees pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axil_wstrb[i]) begin
          mem[aw_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_rdy_q <= 1'b0;
      b_vld_q  <= 1'b0;
      ar_rdy_q <= 1'b0;
      r_vld_q  <= 1'b0;
      rdata_q  <= '0;
      st_vld_q <= 1'b0;
      st_dat_q <= '0;
    end else begin
      aw_rdy_q <= aw_rdy_d;
      b_vld_q  <= b_vld_d;
      ar_rdy_q <= ar_rdy_d;
      r_vld_q  <= r_vld_d;
      rdata_q  <= rdata_d;
      st_vld_q <= st_vld_d;
      st_dat_q <= st_dat_d;
    end
  end

  assign s_axil_awready = aw_rdy_q;
  assign s_axil_wready  = aw_rdy_q;
  assign s_axil_bvalid  = b_vld_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = ar_rdy_q;
  assign s_axil_rvalid  = r_vld_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;

endmodule

// File: doc/axil_ram_responder.md
Name: axil_ram_responder

Overview:
- AXI4-lite slave endpoint: terminates AXI-lite write and read transactions into an on-chip RAM of 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words.
- Sits at the far (responder) end of AXI-lite paths, e.g. behind the width adapter or interconnect.
- Used as scratch/config memory and as the default responder in integration benches.
- Read and write channels are independent; the memory is true dual-access (one write and one read per cycle).

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width.
- PIPELINE_OUTPUT, 0, when 1, adds one read output register stage (+1 read latency).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_axil_awaddr  input  ADDR_WIDTH  write address
- s_axil_awprot  input  3  ignored
- s_axil_awvalid  input  1  write address valid
- s_axil_awready  output  1  write address ready
- s_axil_wdata  input  DATA_WIDTH  write data
- s_axil_wstrb  input  STRB_WIDTH  byte enables
- s_axil_wvalid  input  1  write data valid
- s_axil_wready  output  1  write data ready
- s_axil_bresp  output  2  always 2'b00 (OKAY)
- s_axil_bvalid  output  1  write response valid
- s_axil_bready  input  1  write response ready
- s_axil_araddr  input  ADDR_WIDTH  read address
- s_axil_arprot  input  3  ignored
- s_axil_arvalid  input  1  read address valid
- s_axil_arready  output  1  read address ready
- s_axil_rdata  output  DATA_WIDTH  read data
- s_axil_rresp  output  2  always 2'b00 (OKAY)
- s_axil_rvalid  output  1  read data valid
- s_axil_rready  input  1  read data ready

Behaviour:
- Reset: one clock domain (clk); rst is asynchronous and active-high.
  - While rst is high, awready, wready, bvalid, arready, rvalid = 0; rdata = 0; bresp = rresp = 0.
  - RAM contents are not reset.
  - Reset mid-transaction drops it silently; no response is issued after reset.
- Address decoding:
  - Word index = addr[ADDR_WIDTH-1 : log2(STRB_WIDTH)].
  - Low byte-offset bits are ignored.
  - No decode errors; the full address space aliases onto the RAM.
- Write path:
  - Registered ready. In a cycle where awvalid && wvalid && !awready && (!bvalid || bready):
    - at the next edge, awready and wready are set for exactly one cycle, and bvalid is set;
    - at that same edge, RAM bytes with wstrb[i]=1 are written with wdata[8i+7:8i]; other bytes are unchanged.
  - awready and wready are always asserted together; AW never handshakes without W, and vice versa.
  - AW-only or W-only valid: no ready, no write, wait.
  - bvalid holds until bready. A new write is accepted in the cycle bvalid && bready (back-to-back allowed).
  - Minimum write latency: both valids at cycle 0 -> awready/wready/bvalid high in cycle 1.
  - Throughput: one write per 2 cycles.
- Read path (PIPELINE_OUTPUT=0):
  - In a cycle where arvalid && !arready && (!rvalid || rready):
    - at the next edge, arready is set for one cycle;
    - rdata is loaded from RAM[index];
    - rvalid is set.
  - rvalid and rdata hold until rready.
- Read path (PIPELINE_OUTPUT=1):
  - RAM read data goes into an internal stage; the output register loads from it when !rvalid || rready.
  - Read latency is +1 cycle.
  - An accept is allowed when the internal stage is empty or will drain the same cycle. No data loss under rready=0 backpressure; at most 2 reads are in flight.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-before-write).
- rresp and bresp are constant 2'b00.
- awprot and arprot have no effect.

Test Plan:
- Reset with valids high: all ready/valid outputs stay 0 while rst=1. First edge after release with awvalid=wvalid=1 -> awready=wready=bvalid=1 exactly one cycle later.
- Write 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then write 0x000000AA with wstrb=4'b0001, then read addr 0x10 -> rdata=0xDEADBEAA, rresp=0.
- Issue awvalid alone for 5 cycles, then raise wvalid -> no awready during those 5 cycles; write completes 1 cycle after wvalid rises.
- Hold bready=0 after a write for 4 cycles -> bvalid stays 1 and a second pending write is not accepted; raising bready -> second write is accepted that cycle.
- PIPELINE_OUTPUT=1, 4 back-to-back reads of addrs 0x0, 0x4, 0x8, 0xC (preloaded 1..4) with rready toggling 1,0,0,1 -> data arrives in order 1,2,3,4, none lost or duplicated, first rvalid 2 cycles after arvalid.
- Same-cycle read and write to addr 0x20 (old 0x11111111, new 0x22222222) -> read returns 0x11111111; a subsequent read returns 0x22222222.
